// File: rtl/out_port_mux8.sv
// rtl/out_port_mux8.sv - output-port grant consumer: captures the granted flit into a
// single-entry output register, pops the winning input, and drives a valid/ready link.
module out_port_mux8 #(
  parameter int DW = 64,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      req_in,
  input  logic [8*DW-1:0] data_in,
  output logic [7:0]      arb_req,
  output logic            arb_en,
  input  logic [7:0]      gnt,
  output logic [7:0]      pop,
  output logic            so_valid,
  output logic [DW-1:0]   so_data,
  input  logic            so_ready,
  output logic [CW-1:0]   fwd_cnt,
  output logic            gnt_err
);

  logic          full_q, full_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          drain;
  logic          gnt_any;
  logic          gnt_onehot;
  logic          gnt_unreq;
  logic          load;
  logic          gnt_bad;
  logic [DW-1:0] mux_data;

  assign arb_req = req_in;
  // Depends only on registered state and so_ready, never on gnt: no loop through the arbiter.
  assign arb_en  = ~full_q | so_ready;
  assign drain   = full_q & so_ready;

  assign gnt_any    = |gnt;
  assign gnt_onehot = gnt_any & ((gnt & (gnt - 8'd1)) == 8'd0);
  assign gnt_unreq  = |(gnt & ~req_in);
  assign load       = arb_en & gnt_onehot & ~gnt_unreq;
  assign gnt_bad    = gnt_any & (~arb_en | ~gnt_onehot | gnt_unreq);

  assign pop = (load & ~reset) ? gnt : 8'd0;

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < 8; i++) begin
      mux_data = mux_data | (data_in[i*DW +: DW] & {DW{gnt[i]}});
    end
  end

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    err_d  = err_q | gnt_bad;
    if (load) begin
      full_d = 1'b1;
      data_d = mux_data;
    end else if (drain) begin
      full_d = 1'b0;
    end
    if (drain && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign so_valid = full_q;
  assign so_data  = data_q;
  assign fwd_cnt  = cnt_q;
  assign gnt_err  = err_q;

endmodule

// File: tb/tb_out_port_mux8.sv
// tb/tb_out_port_mux8.sv - directed table-driven bench for out_port_mux8 with a
// behavioural round-robin arbiter; a second instance with CW=4 covers counter saturation.
module tb_out_port_mux8;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    req_in;
  logic [8*DW-1:0] data_in;
  logic [7:0]    gnt, gnt_force, rr_gnt;
  logic          use_arb;
  logic          so_ready;

  logic [7:0]    arb_req_a, pop_a, arb_req_b, pop_b;
  logic          arb_en_a, so_valid_a, gnt_err_a, arb_en_b, so_valid_b, gnt_err_b;
  logic [DW-1:0] so_data_a, so_data_b;
  logic [15:0]   fwd_cnt_a;
  logic [3:0]    fwd_cnt_b;

  logic [2:0]    ptr_q, rr_idx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  out_port_mux8 #(.DW(DW), .CW(16)) dut_a (
    .clk(clk), .reset(reset), .req_in(req_in), .data_in(data_in),
    .arb_req(arb_req_a), .arb_en(arb_en_a), .gnt(gnt), .pop(pop_a),
    .so_valid(so_valid_a), .so_data(so_data_a), .so_ready(so_ready),
    .fwd_cnt(fwd_cnt_a), .gnt_err(gnt_err_a)
  );

  out_port_mux8 #(.DW(DW), .CW(4)) dut_b (
    .clk(clk), .reset(reset), .req_in(req_in), .data_in(data_in),
    .arb_req(arb_req_b), .arb_en(arb_en_b), .gnt(gnt), .pop(pop_b),
    .so_valid(so_valid_b), .so_data(so_data_b), .so_ready(so_ready),
    .fwd_cnt(fwd_cnt_b), .gnt_err(gnt_err_b)
  );

  // Reference round-robin arbiter: first requester at or after the pointer wins.
  always_comb begin
    rr_gnt = 8'd0;
    rr_idx = 3'd0;
    if (arb_en_a) begin
      for (int k = 0; k < 8; k++) begin
        if (rr_gnt == 8'd0 && req_in[3'(ptr_q + 3'(k))]) begin
          rr_gnt[3'(ptr_q + 3'(k))] = 1'b1;
          rr_idx = 3'(ptr_q + 3'(k));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 3'd0;
    else if (use_arb && rr_gnt != 8'd0) ptr_q <= rr_idx + 3'd1;
  end

  assign gnt = use_arb ? rr_gnt : gnt_force;

  function automatic logic [DW-1:0] dval(int i);
    return 64'hA5 | (64'(i) << 8) | (64'(i) << 60);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]    req;
    logic [7:0]    g;
    logic          rdy;
    logic [7:0]    e_pop;
    logic          e_en;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_err;
    logic [15:0]   e_cnt;
  } vec_t;

  function automatic vec_t mk(logic [7:0] req, logic [7:0] g, logic rdy, logic [7:0] e_pop,
                              logic e_en, logic e_valid, logic [DW-1:0] e_data, logic e_err,
                              logic [15:0] e_cnt);
    vec_t v;
    v.req = req; v.g = g; v.rdy = rdy; v.e_pop = e_pop; v.e_en = e_en;
    v.e_valid = e_valid; v.e_data = e_data; v.e_err = e_err; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_in = 8'd0; gnt_force = 8'd0; so_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t tbl[11];

  initial begin
    reset = 1'b1; req_in = 8'd0; gnt_force = 8'd0; so_ready = 1'b0; use_arb = 1'b0;
    for (int i = 0; i < 8; i++) data_in[i*DW +: DW] = dval(i);

    tbl[0]  = mk(8'h01, 8'h01, 1'b1, 8'h01, 1'b1, 1'b1, dval(0), 1'b0, 16'd0);
    tbl[1]  = mk(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, dval(0), 1'b0, 16'd1);
    tbl[2]  = mk(8'h08, 8'h08, 1'b0, 8'h08, 1'b1, 1'b1, dval(3), 1'b0, 16'd1);
    tbl[3]  = mk(8'h0C, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, dval(3), 1'b0, 16'd1);
    tbl[4]  = mk(8'h0C, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, dval(3), 1'b0, 16'd1);
    tbl[5]  = mk(8'h0C, 8'h04, 1'b1, 8'h04, 1'b1, 1'b1, dval(2), 1'b0, 16'd2);
    tbl[6]  = mk(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, dval(2), 1'b0, 16'd3);
    tbl[7]  = mk(8'h03, 8'h03, 1'b1, 8'h00, 1'b1, 1'b0, dval(2), 1'b1, 16'd3);
    tbl[8]  = mk(8'h0F, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0, dval(2), 1'b1, 16'd3);
    tbl[9]  = mk(8'h01, 8'h01, 1'b1, 8'h01, 1'b1, 1'b1, dval(0), 1'b1, 16'd3);
    tbl[10] = mk(8'h00, 8'h02, 1'b0, 8'h00, 1'b0, 1'b1, dval(0), 1'b1, 16'd3);

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_arb_en", 64'(arb_en_a), 64'd1);
    chk("rst_pop", 64'(pop_a), 64'd0);
    chk("rst_valid", 64'(so_valid_a), 64'd0);
    chk("rst_data", so_data_a, 64'd0);
    chk("rst_cnt", 64'(fwd_cnt_a), 64'd0);
    chk("rst_err", 64'(gnt_err_a), 64'd0);
    reset = 1'b0;

    // Directed vector table with forced grants
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      req_in = tbl[i].req; gnt_force = tbl[i].g; so_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_arb_req", i), 64'(arb_req_a), 64'(tbl[i].req));
      chk($sformatf("v%0d_pop", i), 64'(pop_a), 64'(tbl[i].e_pop));
      chk($sformatf("v%0d_arb_en", i), 64'(arb_en_a), 64'(tbl[i].e_en));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 64'(so_valid_a), 64'(tbl[i].e_valid));
      chk($sformatf("v%0d_data", i), so_data_a, tbl[i].e_data);
      chk($sformatf("v%0d_err", i), 64'(gnt_err_a), 64'(tbl[i].e_err));
      chk($sformatf("v%0d_cnt", i), 64'(fwd_cnt_a), 64'(tbl[i].e_cnt));
    end

    // Grant while arb_en=0 is an error; backpressure holds the flit; reset discards it.
    do_reset();
    req_in = 8'h01; gnt_force = 8'h01; so_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp_load_valid", 64'(so_valid_a), 64'd1);
    @(negedge clk); #1;
    chk("bp_blocked_pop", 64'(pop_a), 64'd0);
    @(posedge clk); #1;
    chk("bp_err_rise", 64'(gnt_err_a), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_in = 8'h0C; gnt_force = 8'h00; so_ready = 1'b0;
      #1;
      chk($sformatf("bp%0d_arb_en", c), 64'(arb_en_a), 64'd0);
      chk($sformatf("bp%0d_pop", c), 64'(pop_a), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_data", c), so_data_a, dval(0));
      chk($sformatf("bp%0d_valid", c), 64'(so_valid_a), 64'd1);
    end
    @(negedge clk);
    reset = 1'b1; req_in = 8'h01; gnt_force = 8'h01; so_ready = 1'b1;
    #1;
    chk("rstmid_pop", 64'(pop_a), 64'd0);
    @(posedge clk); #1;
    chk("rstmid_valid", 64'(so_valid_a), 64'd0);
    chk("rstmid_data", so_data_a, 64'd0);
    chk("rstmid_cnt", 64'(fwd_cnt_a), 64'd0);
    chk("rstmid_err", 64'(gnt_err_a), 64'd0);
    chk("rstmid_arb_en", 64'(arb_en_a), 64'd1);

    // Rotation with the reference arbiter, then saturation on the CW=4 instance
    do_reset();
    use_arb = 1'b1;
    for (int k = 0; k < 36; k++) begin
      if (k == 16) begin
        @(negedge clk);
        req_in = 8'h00; so_ready = 1'b1;
        @(posedge clk); #1;
        chk("rot_cnt16", 64'(fwd_cnt_a), 64'd16);
        chk("rot_cnt4_sat", 64'(fwd_cnt_b), 64'd15);
        chk("rot_err", 64'(gnt_err_a), 64'd0);
        chk("rot_idle_valid", 64'(so_valid_a), 64'd0);
      end
      @(negedge clk);
      req_in = 8'hFF; so_ready = 1'b1;
      #1;
      chk($sformatf("rot%0d_pop", k), 64'(pop_a), 64'(8'h01 << (k % 8)));
      @(posedge clk); #1;
      chk($sformatf("rot%0d_data", k), so_data_a, dval(k % 8));
      chk($sformatf("rot%0d_valid", k), 64'(so_valid_a), 64'd1);
    end
    @(negedge clk);
    req_in = 8'h00; so_ready = 1'b1;
    @(posedge clk); #1;
    chk("sat_cnt16", 64'(fwd_cnt_a), 64'd36);
    chk("sat_cnt4", 64'(fwd_cnt_b), 64'd15);
    chk("sat_err", 64'(gnt_err_b), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/out_port_mux8.md
# out_port_mux8

Output-port grant consumer for the 8-way round-robin arbiter. It presents the eight input requests to the arbiter and gates the arbiter with `arb_en`. It then uses the returned one-hot grant to capture the winning flit into a single-entry output register, pops the winning input, and drives the downstream link with a valid/ready handshake. One instance sits behind each arbiter at every router output port. The block also keeps a forwarded-flit counter and a sticky protocol-error flag for debug.

## Interface
- `DW`, 64, flit width in bits
- `CW`, 16, width of the forwarded-flit counter

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_in`  in  8  per-input "flit available" flags
- `data_in`  in  8*DW  packed input flits; input i occupies bits [i*DW +: DW]
- `arb_req`  out  8  request vector to arbiter; equals `req_in` combinationally
- `arb_en`  out  1  arbiter enable
- `gnt`  in  8  one-hot grant from arbiter; all-zero when `arb_en`=0
- `pop`  out  8  one-hot dequeue strobe to the granted input buffer
- `so_valid`  out  1  output register holds a flit
- `so_data`  out  DW  output flit
- `so_ready`  in  1  downstream accepts the flit this cycle
- `fwd_cnt`  out  CW  count of flits accepted downstream; saturating
- `gnt_err`  out  1  sticky protocol-error flag

## Operation
- State:
  - `full` (reflected on `so_valid`)
  - `so_data` register
  - `fwd_cnt`
  - `gnt_err`
- `drain` = `full & so_ready`.
- `arb_en = ~full | so_ready`. This is combinational from registered `full` and the `so_ready` input only. It never depends on `gnt`, so there is no combinational loop through the arbiter.
- A grant is valid when all of the following hold: `arb_en`=1; `gnt` has exactly one bit set; `(gnt & ~req_in)` == 0.
- `load` = valid grant.
- `pop = load ? gnt : 8'b0`. This is combinational, in the same cycle as the grant. Input buffers dequeue on the clock edge.
- Next state of the output register, by case:
  - `load`: `so_data <= data_in[idx*DW +: DW]`, where idx is the index of the set `gnt` bit; `full <= 1`. This covers simultaneous drain and load (pass-through at 1 flit/cycle).
  - `~load & drain`: `full <= 0`. `so_data` holds its old value (don't-care).
  - Otherwise: hold.
- `fwd_cnt` increments on every `drain` and saturates at 2^CW-1 (it does not wrap).
- `gnt_err` sets to 1 and stays set until reset when either:
  - `gnt` is nonzero while `arb_en`=0; or
  - `gnt` is nonzero but not one-hot; or
  - `gnt` selects an input with `req_in`=0.
- An erroneous grant never loads and never pops.
- `gnt` all-zero with `arb_en`=1 (no requesters) is legal: no action, no error.
- Data mux is AND-OR over one-hot `gnt`. Its result is used only when `load`=1.

## Timing
- Reset values: `so_valid`=0, `so_data`=0, `fwd_cnt`=0, `gnt_err`=0. `pop`=0 and `arb_en`=1 during and immediately after reset, since `full`=0.
- Reset mid-operation: a held flit is discarded; no `pop` is issued in the reset cycle. While `reset`=1, `pop` is forced to 0 regardless of `gnt`.
- Latency: grant in cycle T, `so_valid`=1 with the flit in cycle T+1.
- Throughput: 1 flit/cycle while `so_ready`=1 and requests are present.
- Backpressure: while `full & ~so_ready`, `arb_en`=0, so no grant, no pop, and the arbiter pointer does not advance. `so_data` and `so_valid` remain stable until accepted.
- Handshake: a transfer occurs on the edge where `so_valid & so_ready`. `so_valid` never drops without a transfer. `so_ready` may toggle freely.
- Counter saturation: at `fwd_cnt`=2^CW-1 a further drain leaves the value unchanged.

## Test plan
- Reset, then `req_in`=8'h01, `data_in[0]`=64'hA5, `so_ready`=1: `pop`=8'h01 in cycle 1; `so_valid`=1 and `so_data`=64'hA5 in cycle 2; `fwd_cnt`=1 after the transfer.
- `req_in`=8'hFF held, `so_ready`=1 for 16 cycles with the real arbiter attached: pops rotate 0,1,…,7,0,…; one flit per cycle; `fwd_cnt`=16; `gnt_err`=0.
- Output full and `so_ready`=0 for 5 cycles with `req_in`=8'h0C: `arb_en`=0, `pop`=0, `so_data` stable. Then `so_ready`=1: the held flit transfers and input 2 is loaded in the same cycle.
- Force `gnt`=8'h03, then `gnt`=8'h10 with `req_in[4]`=0: `pop`=0, no load, `gnt_err` rises and stays 1 until `reset`.
- Preload `fwd_cnt` near saturation (CW=4), then stream 20 flits: `fwd_cnt` stops at 15.
- Assert `reset` while `so_valid`=1 and `so_ready`=0: the next cycle shows `so_valid`=0, `so_data`=0, `fwd_cnt`=0, `gnt_err`=0, and no `pop` in the reset cycle.
